multi_counter_status_q: RTL and testbench
=========================================

Name: multi_counter_status_q

Overview:
Downstream consumer of the multi-counter pipeline's status interface. Captures every emitted query result (status pass with query flag set) into a Q_N-entry FIFO. Presents results to the host over a valid/ack handshake. Returns a combinational stall to the command source so that outstanding queries can never exceed FIFO capacity; the counter pipeline itself has no backpressure.

Parameters:
CNTRS_N, 256, number of counters
CNTRS_W, 32, counter data width
CNTRS_ID_W, $clog2(CNTRS_N), counter id width
Q_N, 8, FIFO depth; power of two, >= 2
Q_CNT_W, $clog2(Q_N)+1, occupancy/in-flight counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_pass  in  1  command issued to counter pipeline this cycle
cmd_qry  in  1  issued command carries the OUTPUT op (qualified by cmd_pass)
cmd_stall  out  1  combinational; source must not issue a query command while high
status_pass  in  1  pipeline status valid
status_qry  in  1  status is an emitted query result
status_id  in  CNTRS_ID_W  counter id of result
status_dat  in  CNTRS_W  counter value of result
rsp_vld  out  1  FIFO head valid
rsp_id  out  CNTRS_ID_W  head id
rsp_dat  out  CNTRS_W  head data
rsp_ack  in  1  host consumes head when rsp_vld & rsp_ack
ovf_r  out  1  sticky overflow (only with MULTI_COUNTER_STATUS_Q_ERR_EN)
drop_cnt_r  out  16  dropped-result count (only with MULTI_COUNTER_STATUS_Q_ERR_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; all state registers are asynchronously cleared while rst_n is low.
- Reset values: occupancy 0, inflight 0, read/write pointers 0, rsp_vld 0, cmd_stall 0, ovf_r 0, drop_cnt_r 0. rsp_id and rsp_dat are don't-care while rsp_vld is 0.
- Event definitions:
  - push = status_pass & status_qry
  - pop = rsp_vld & rsp_ack
  - issue = cmd_pass & cmd_qry
- inflight counter:
  - +1 on issue, -1 on push; simultaneous issue and push leaves it unchanged.
  - It never underflows: a push with inflight == 0 is still captured, and inflight saturates at 0.
- Stall: cmd_stall = (occ + inflight) >= Q_N, computed at Q_CNT_W+1 bits to avoid wrap. Non-query commands may issue regardless of stall.
- Push: writes {status_id, status_dat} at wptr; wptr advances modulo Q_N; occ +1.
- Pop: rptr advances modulo Q_N; occ -1.
- Simultaneous push and pop: occ unchanged. This is legal even when full, because the pop frees the slot that the push uses.
- Full with push and no pop:
  - The entry is dropped; FIFO contents and pointers are unchanged.
  - inflight still decrements.
  - This only occurs if the source violated cmd_stall.
- Latency: a result presented on the status_* inputs at cycle N is visible on rsp_* at N+1 when the FIFO was empty. Results are delivered in arrival order.
- rsp_vld = (occ != 0). Head data is read combinationally from the storage array at rptr.
- rsp_ack without rsp_vld is ignored; no state change.
- Reset mid-operation: all queued and in-flight bookkeeping is discarded. Upstream must be reset in the same domain.

Optional Feature:
MULTI_COUNTER_STATUS_Q_ERR_EN
- Defined:
  - ovf_r sets on a dropped push and clears only on reset.
  - drop_cnt_r increments on each dropped push and saturates at 16'hFFFF.
- Undefined: both ports and their logic are absent; overflows drop silently.

Decomposition:
- multi_counter_pkg gains rsp_t, a packed struct {id, dat}. The id field is sized from the package-level defaults, so the block uses local typedefs when its parameters are overridden.
- One sub-module, multi_counter_status_fifo, parameterised on W and N. It has push/pop, occupancy and full/empty, with rsp_t as payload.
- Stall logic, inflight counter and the error counters stay in the top module.

Test Plan:
- Reset with rst_n low for 3 cycles, asserted asynchronously mid-cycle -> all outputs 0 immediately; rsp_vld remains 0 after release.
- Single query: issue, then push id=5 dat=0x1234 three cycles later -> rsp_vld=1 next cycle with rsp_id=5, rsp_dat=0x1234; rsp_ack -> rsp_vld=0 next cycle; inflight returns to 0.
- Fill, Q_N=8: issue 8 queries with rsp_ack=0 -> cmd_stall rises after the 8th issue; 8 pushes land with ids 0..7 in order; ack 1 entry -> cmd_stall falls.
- Full with simultaneous push and pop: occ=8, push id=9 with rsp_ack=1 -> head id 0 leaves, id 9 enqueued, occ stays 8, no drop.
- Stall violation with MULTI_COUNTER_STATUS_Q_ERR_EN: push while full without ack -> FIFO unchanged, ovf_r=1, drop_cnt_r=1; a second drop -> drop_cnt_r=2.
- Non-query traffic: 20 cycles of cmd_pass=1, cmd_qry=0 and status_pass=1, status_qry=0 -> no pushes, inflight stays 0, cmd_stall stays 0.

Source files
------------

// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared defaults, response payload type and helpers for the multi-counter blocks.
`default_nettype none

package multi_counter_pkg;

  localparam int CNTRS_N    = 256;
  localparam int CNTRS_W    = 32;
  localparam int CNTRS_ID_W = $clog2(CNTRS_N);
  localparam int Q_N        = 8;
  localparam int Q_CNT_W    = $clog2(Q_N) + 1;

  typedef struct packed {
    logic [CNTRS_ID_W-1:0] id;
    logic [CNTRS_W-1:0]    dat;
  } rsp_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_counter_status_fifo.sv
// multi_counter_status_fifo: N-entry FIFO with fall-through head read; a push into a full FIFO
// succeeds only when a pop frees the slot in the same cycle, otherwise it is discarded.
`default_nettype none

module multi_counter_status_fifo
  import multi_counter_pkg::*;
#(
  parameter int W     = $bits(rsp_t),
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] occ_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(N);
  localparam logic [CNT_W-1:0] FULL_LVL = N[CNT_W-1:0];

  logic [W-1:0]     mem_q [N];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full_o  = (occ_q == FULL_LVL);
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // N is a power of two, so natural pointer wrap gives modulo-N addressing.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/multi_counter_status_q.sv
// multi_counter_status_q: captures query results into a FIFO for the host and stalls query issue at capacity.
// Optional MULTI_COUNTER_STATUS_Q_ERR_EN adds sticky overflow flag ovf_r and saturating drop_cnt_r.
`default_nettype none

module multi_counter_status_q
  import multi_counter_pkg::*;
#(
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int Q_N        = 8,
  parameter int Q_CNT_W    = $clog2(Q_N) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_pass,
  input  logic                  cmd_qry,
  output logic                  cmd_stall,
  input  logic                  status_pass,
  input  logic                  status_qry,
  input  logic [CNTRS_ID_W-1:0] status_id,
  input  logic [CNTRS_W-1:0]    status_dat,
  output logic                  rsp_vld,
  output logic [CNTRS_ID_W-1:0] rsp_id,
  output logic [CNTRS_W-1:0]    rsp_dat,
  input  logic                  rsp_ack
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
  ,
  output logic                  ovf_r,
  output logic [15:0]           drop_cnt_r
`endif
);

  // Local payload type so overridden id/data widths are honoured.
  typedef struct packed {
    logic [CNTRS_ID_W-1:0] id;
    logic [CNTRS_W-1:0]    dat;
  } q_rsp_t;

  localparam logic [Q_CNT_W:0]   STALL_LVL = Q_N[Q_CNT_W:0];
  localparam logic [Q_CNT_W-1:0] INFL_MAX  = '1;

  logic               push, pop, issue;
  logic               fifo_full, fifo_empty;
  logic [Q_CNT_W-1:0] occ;
  logic [Q_CNT_W-1:0] inflight_q, inflight_d;
  logic [Q_CNT_W:0]   load;
  q_rsp_t             wr_ent, rd_ent;

  assign push  = status_pass & status_qry;
  assign issue = cmd_pass & cmd_qry;
  assign pop   = rsp_vld & rsp_ack;

  assign wr_ent.id  = status_id;
  assign wr_ent.dat = status_dat;

  multi_counter_status_fifo #(
    .W     ($bits(q_rsp_t)),
    .N     (Q_N),
    .CNT_W (Q_CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_ent),
    .pop_i   (pop),
    .rdata_o (rd_ent),
    .occ_o   (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_vld = ~fifo_empty;
  assign rsp_id  = rd_ent.id;
  assign rsp_dat = rd_ent.dat;

  // A push with nothing outstanding is still captured; the count just holds at zero.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !push) begin
      if (inflight_q != INFL_MAX) inflight_d = inflight_q + 1'b1;
    end else if (push && !issue) begin
      if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  assign load      = {1'b0, occ} + {1'b0, inflight_q};
  assign cmd_stall = (load >= STALL_LVL);

`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
  logic        drop;
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  assign drop = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q      <= 1'b1;
      drop_cnt_q <= sat_inc16(drop_cnt_q);
    end
  end

  assign ovf_r      = ovf_q;
  assign drop_cnt_r = drop_cnt_q;
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_counter_status_q.sv
// tb_multi_counter_status_q: vector table, directed corner sequences and random traffic vs a queue model.
// Define MULTI_COUNTER_STATUS_Q_ERR_EN to also check ovf_r / drop_cnt_r.
`default_nettype none

module tb_multi_counter_status_q;

  localparam int Q_N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_pass, cmd_qry, cmd_stall;
  logic        status_pass, status_qry;
  logic [7:0]  status_id;
  logic [31:0] status_dat;
  logic        rsp_vld;
  logic [7:0]  rsp_id;
  logic [31:0] rsp_dat;
  logic        rsp_ack;
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
  logic        ovf_r;
  logic [15:0] drop_cnt_r;
`endif

  always #5 clk = ~clk;

  multi_counter_status_q dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_pass    (cmd_pass),
    .cmd_qry     (cmd_qry),
    .cmd_stall   (cmd_stall),
    .status_pass (status_pass),
    .status_qry  (status_qry),
    .status_id   (status_id),
    .status_dat  (status_dat),
    .rsp_vld     (rsp_vld),
    .rsp_id      (rsp_id),
    .rsp_dat     (rsp_dat),
    .rsp_ack     (rsp_ack)
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
    ,
    .ovf_r       (ovf_r),
    .drop_cnt_r  (drop_cnt_r)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] dat;
  } ent_t;

  ent_t mq[$];
  int   m_infl;
  int   m_drops;
  bit   m_ovf;

  typedef struct {
    bit          cp, cq, sp, sq, ack;
    logic [7:0]  id;
    logic [31:0] dat;
    bit          e_vld;
    logic [7:0]  e_id;
    logic [31:0] e_dat;
    bit          e_stall;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl  = 0;
    m_drops = 0;
    m_ovf   = 0;
  endtask

  function automatic bit model_stall();
    return (mq.size() + m_infl) >= Q_N;
  endfunction

  task automatic model_step(input bit cp, cq, sp, sq, input logic [7:0] id,
                            input logic [31:0] dat, input bit ack);
    int sz;
    bit pop, push, iss;
    ent_t e;
    sz   = mq.size();
    pop  = (sz != 0) && ack;
    push = sp && sq;
    iss  = cp && cq;
    if (pop) mq.delete(0);
    if (push) begin
      if (sz < Q_N || pop) begin
        e.id  = id;
        e.dat = dat;
        mq.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    m_infl = m_infl + int'(iss) - int'(push);
    if (m_infl < 0) m_infl = 0;
  endtask

  task automatic check_model();
    chk("mdl_vld", rsp_vld, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("mdl_id", rsp_id, mq[0].id);
      chk("mdl_dat", rsp_dat, mq[0].dat);
    end
    chk("mdl_stall", cmd_stall, model_stall());
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
    chk("mdl_ovf", ovf_r, m_ovf);
    chk("mdl_drops", drop_cnt_r, m_drops);
`endif
  endtask

  // Called at posedge+1: drive, take one edge, then compare at the new posedge+1.
  task automatic cyc(input bit cp, cq, sp, sq, input logic [7:0] id,
                     input logic [31:0] dat, input bit ack);
    cmd_pass    = cp;
    cmd_qry     = cq;
    status_pass = sp;
    status_qry  = sq;
    status_id   = id;
    status_dat  = dat;
    rsp_ack     = ack;
    @(posedge clk);
    model_step(cp, cq, sp, sq, id, dat, ack);
    #1;
    check_model();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_bias;
    logic [7:0] drain_ids[7];
    bit cp, cq, sp, sq, ack;

    rst_n = 1'b0;
    cmd_pass = 0; cmd_qry = 0; status_pass = 0; status_qry = 0;
    status_id = 0; status_dat = 0; rsp_ack = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", rsp_vld, 1'b0);
    chk("rst_stall", cmd_stall, 1'b0);
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
    chk("rst_ovf", ovf_r, 1'b0);
    chk("rst_drop", drop_cnt_r, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_vld", rsp_vld, 1'b0);

    // cp cq sp sq ack  id  dat  | vld id dat stall
    tbl[0]  = '{1, 1, 0, 0, 0, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[1]  = '{0, 0, 0, 0, 0, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[2]  = '{0, 0, 0, 0, 0, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[3]  = '{0, 0, 1, 1, 0, 8'd5, 32'h1234,      1, 8'd5, 32'h1234,      0};
    tbl[4]  = '{0, 0, 0, 0, 1, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[5]  = '{0, 0, 0, 0, 1, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[6]  = '{0, 0, 1, 1, 0, 8'd1, 32'hAAAA_0001, 1, 8'd1, 32'hAAAA_0001, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 8'd2, 32'hBBBB_0002, 1, 8'd1, 32'hAAAA_0001, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 8'd0, 32'h0,         1, 8'd2, 32'hBBBB_0002, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};
    tbl[10] = '{1, 1, 1, 1, 0, 8'd3, 32'h0000_0033, 1, 8'd3, 32'h0000_0033, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 8'd0, 32'h0,         0, 8'd0, 32'h0,         0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].cp, tbl[i].cq, tbl[i].sp, tbl[i].sq, tbl[i].id, tbl[i].dat, tbl[i].ack);
      chk("tbl_vld", rsp_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk("tbl_id", rsp_id, tbl[i].e_id);
        chk("tbl_dat", rsp_dat, tbl[i].e_dat);
      end
      chk("tbl_stall", cmd_stall, tbl[i].e_stall);
    end

    // Fill: eight outstanding queries reach capacity.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 8'd0, 32'h0, 0);
      chk("fill_stall", cmd_stall, i == 7);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 1, 8'(i), 32'hC000_0000 + i, 0);
      chk("land_stall", cmd_stall, 1'b1);
    end
    chk("full_head", rsp_id, 8'd0);

    cyc(0, 0, 1, 1, 8'd9, 32'h0000_0009, 1);
    chk("pp_head", rsp_id, 8'd1);
    chk("pp_stall", cmd_stall, 1'b1);

`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
    cyc(0, 0, 1, 1, 8'hEE, 32'hDEAD_0001, 0);
    chk("drop1_ovf", ovf_r, 1'b1);
    chk("drop1_cnt", drop_cnt_r, 16'd1);
    chk("drop1_head", rsp_id, 8'd1);
    cyc(0, 0, 1, 1, 8'hEF, 32'hDEAD_0002, 0);
    chk("drop2_cnt", drop_cnt_r, 16'd2);
`endif

    cyc(0, 0, 0, 0, 8'd0, 32'h0, 1);
    chk("ack_unstall", cmd_stall, 1'b0);

    drain_ids = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
    for (int i = 0; i < 7; i++) begin
      chk("drain_id", rsp_id, drain_ids[i]);
      cyc(0, 0, 0, 0, 8'd0, 32'h0, 1);
    end
    chk("drain_empty", rsp_vld, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1, 0, 8'(i), 32'h5555_0000 + i, 0);
      chk("nq_vld", rsp_vld, 1'b0);
      chk("nq_stall", cmd_stall, 1'b0);
    end

    // Random traffic; query issue respects stall, stray pushes may overflow.
    ack_bias = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) ack_bias = int'($urandom_range(0, 4));
      cq  = !model_stall() && ($urandom_range(0, 2) == 0);
      cp  = cq || ($urandom_range(0, 1) == 1);
      sq  = (m_infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      sp  = sq || ($urandom_range(0, 3) == 0);
      ack = (int'($urandom_range(0, 3)) < ack_bias);
      cyc(cp, cq, sp, sq, 8'($urandom), $urandom, ack);
    end

    cyc(1, 1, 0, 0, 8'd0, 32'h0, 0);
    cyc(0, 0, 1, 1, 8'h42, 32'h4242_4242, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", rsp_vld, 1'b0);
    chk("arst_stall", cmd_stall, 1'b0);
`ifdef MULTI_COUNTER_STATUS_Q_ERR_EN
    chk("arst_ovf", ovf_r, 1'b0);
    chk("arst_drop", drop_cnt_r, 16'd0);
`endif
    model_reset();
    cmd_pass = 0; cmd_qry = 0; status_pass = 0; status_qry = 0; rsp_ack = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_vld", rsp_vld, 1'b0);
    cyc(0, 0, 0, 0, 8'd0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
